// File: rtl/ibex2ahbl_dbus_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibex2ahbl_dbus_bridge_if: Ibex data-port and AHB-Lite master bundle.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ibex2ahbl_dbus_bridge_if #(
  parameter int ADDR_W = 32
) ();
  // Ibex LSU side
  logic              data_req;
  logic              data_gnt;
  logic              data_rvalid;
  logic              data_we;
  logic [3:0]        data_be;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic [6:0]        data_wdata_intg;
  logic [31:0]       data_rdata;
  logic [6:0]        data_rdata_intg;
  logic              data_err;

  // AHB-Lite side
  logic [ADDR_W-1:0] dmem_haddr;
  logic [1:0]        dmem_htrans;
  logic              dmem_hwrite;
  logic [2:0]        dmem_hsize;
  logic [2:0]        dmem_hburst;
  logic [3:0]        dmem_hprot;
  logic              dmem_hmastlock;
  logic [31:0]       dmem_hwdata;
  logic              dmem_hready;
  logic [31:0]       dmem_hrdata;
  logic              dmem_hresp;

  // master: the bridge itself; slave: the core/interconnect environment
  modport master (
    input  data_req, data_we, data_be, data_addr, data_wdata, data_wdata_intg,
    input  dmem_hready, dmem_hrdata, dmem_hresp,
    output data_gnt, data_rvalid, data_rdata, data_rdata_intg, data_err,
    output dmem_haddr, dmem_htrans, dmem_hwrite, dmem_hsize, dmem_hburst,
    output dmem_hprot, dmem_hmastlock, dmem_hwdata
  );

  modport slave (
    output data_req, data_we, data_be, data_addr, data_wdata, data_wdata_intg,
    output dmem_hready, dmem_hrdata, dmem_hresp,
    input  data_gnt, data_rvalid, data_rdata, data_rdata_intg, data_err,
    input  dmem_haddr, dmem_htrans, dmem_hwrite, dmem_hsize, dmem_hburst,
    input  dmem_hprot, dmem_hmastlock, dmem_hwdata
  );
endinterface
`default_nettype wire

// File: rtl/ibex2ahbl_dbus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibex2ahbl_dbus_bridge: pipelined Ibex data port to AHB-Lite master bridge. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ibex2ahbl_dbus_bridge #(
  parameter int         ADDR_W     = 32,
  parameter logic [3:0] HPROT_DATA = 4'b0011,
  parameter int         CNT_W      = 8
) (
  input  wire                     clk,
  input  wire                     rst_n,
  ibex2ahbl_dbus_bridge_if.master bus,
  output logic [CNT_W-1:0]        err_count
);

  localparam logic [1:0]       c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]       c_HTRANS_NONSEQ = 2'b10;
  localparam logic [CNT_W-1:0] c_CNT_MAX       = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             dp_valid_q,   dp_valid_d;
  logic             dp_write_q,   dp_write_d;
  logic             dp_illegal_q, dp_illegal_d;
  logic [31:0]      hwdata_q,     hwdata_d;
  logic [CNT_W-1:0] err_cnt_q,    err_cnt_d;

  logic       w_legal;
  logic [2:0] w_size;
  logic [1:0] w_off;
  logic       w_dp_done;
  logic       w_slot_free;
  logic       w_err_first;
  logic       w_gnt;
  logic       w_rsp_err;
  logic       w_unused;

  // Only naturally aligned byte, halfword and word enables map onto AHB.
  always_comb begin
    w_legal = 1'b1;
    w_size  = 3'b000;
    w_off   = 2'b00;
    case (bus.data_be)
      4'b0001: begin w_size = 3'b000; w_off = 2'b00; end
      4'b0010: begin w_size = 3'b000; w_off = 2'b01; end
      4'b0100: begin w_size = 3'b000; w_off = 2'b10; end
      4'b1000: begin w_size = 3'b000; w_off = 2'b11; end
      4'b0011: begin w_size = 3'b001; w_off = 2'b00; end
      4'b1100: begin w_size = 3'b001; w_off = 2'b10; end
      4'b1111: begin w_size = 3'b010; w_off = 2'b00; end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal transfers never reach the bus, so they complete without HREADY.
  assign w_dp_done   = dp_valid_q & (dp_illegal_q | bus.dmem_hready);
  assign w_slot_free = ~dp_valid_q | w_dp_done;
  assign w_err_first = dp_valid_q & ~dp_illegal_q & bus.dmem_hresp & ~bus.dmem_hready;
  assign w_gnt       = rst_n & bus.data_req & w_slot_free & bus.dmem_hready & ~w_err_first;
  assign w_rsp_err   = w_dp_done & (dp_illegal_q | bus.dmem_hresp);

  always_comb begin
    dp_valid_d   = dp_valid_q;
    dp_write_d   = dp_write_q;
    dp_illegal_d = dp_illegal_q;
    hwdata_d     = hwdata_q;
    err_cnt_d    = err_cnt_q;
    if (w_gnt) begin
      dp_valid_d   = 1'b1;
      dp_write_d   = bus.data_we;
      dp_illegal_d = ~w_legal;
      if (w_legal && bus.data_we) begin
        hwdata_d = bus.data_wdata;
      end
    end else if (w_dp_done) begin
      dp_valid_d = 1'b0;
    end
    if (w_rsp_err && (err_cnt_q != c_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid_q   <= 1'b0;
      dp_write_q   <= 1'b0;
      dp_illegal_q <= 1'b0;
      hwdata_q     <= 32'h0;
      err_cnt_q    <= '0;
    end else begin
      dp_valid_q   <= dp_valid_d;
      dp_write_q   <= dp_write_d;
      dp_illegal_q <= dp_illegal_d;
      hwdata_q     <= hwdata_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.data_gnt        = w_gnt;
  assign bus.data_rvalid     = w_dp_done;
  assign bus.data_err        = w_rsp_err;
  assign bus.data_rdata      = bus.dmem_hrdata;
  assign bus.data_rdata_intg = 7'h00;

  assign bus.dmem_htrans    = (w_gnt && w_legal) ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
  assign bus.dmem_haddr     = {bus.data_addr[ADDR_W-1:2], w_off};
  assign bus.dmem_hwrite    = bus.data_we;
  assign bus.dmem_hsize     = w_size;
  assign bus.dmem_hburst    = 3'b000;
  assign bus.dmem_hprot     = HPROT_DATA;
  assign bus.dmem_hmastlock = 1'b0;
  assign bus.dmem_hwdata    = hwdata_q;

  assign err_count = err_cnt_q;

  // The lane offset comes from the byte enables; integrity and direction of the
  // data phase are carried but never consumed.
  assign w_unused = ^{bus.data_wdata_intg, bus.data_addr[1:0], dp_write_q};

endmodule
`default_nettype wire

// File: tb/tb_ibex2ahbl_dbus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ibex2ahbl_dbus_bridge: directed bench with transaction-level model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ibex2ahbl_dbus_bridge;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [CNT_W-1:0] err_count;

  ibex2ahbl_dbus_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  ibex2ahbl_dbus_bridge #(
    .ADDR_W(ADDR_W), .HPROT_DATA(4'b0011), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Slave response plan, consumed one entry per accepted NONSEQ address phase
  typedef struct {
    int          waits;
    bit          err;
    logic [31:0] rdata;
  } plan_t;
  plan_t plan_q[$];

  // Byte-enable rule: n enables must be 1/2/4 contiguous lanes aligned to n.
  function automatic void bedec(input logic [3:0] be, output bit legal,
                                output logic [2:0] size, output logic [1:0] off);
    int n;
    n     = $countones(be);
    legal = 1'b0;
    size  = 3'd0;
    off   = 2'd0;
    for (int o = 0; o < 4; o++) begin
      if ((n == 1 || n == 2 || n == 4) && (o % n == 0) && (be == 4'(((1 << n) - 1) << o))) begin
        legal = 1'b1;
        off   = 2'(o);
        size  = (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : 3'd2;
      end
    end
  endfunction

  // AHB-Lite slave: wait states, two-cycle ERROR, read data from the plan
  plan_t       s_p;
  bit          s_active, s_err, s_errph, s_fin, s_cap;
  int          s_waits;
  logic [31:0] s_rdata, s_addr;
  initial begin
    bus.dmem_hready = 1'b1;
    bus.dmem_hresp  = 1'b0;
    bus.dmem_hrdata = 32'h0;
    s_active = 0; s_err = 0; s_errph = 0; s_waits = 0; s_rdata = 32'h0;
    forever begin
      @(negedge clk);
      s_fin  = s_active && bus.dmem_hready;
      s_cap  = rst_n && (bus.dmem_htrans == 2'b10) && bus.dmem_hready;
      s_addr = bus.dmem_haddr;
      @(posedge clk); #1;
      if (!rst_n) begin
        s_active = 0;
      end else begin
        if (s_fin) s_active = 0;
        if (s_cap) begin
          s_active = 1; s_errph = 0;
          if (plan_q.size() > 0) begin
            s_p = plan_q.pop_front();
            s_waits = s_p.waits; s_err = s_p.err; s_rdata = s_p.rdata;
          end else begin
            s_waits = 0; s_err = 0; s_rdata = {16'hC0DE, s_addr[15:0]};
          end
        end
      end
      if (s_active && s_waits > 0) begin
        bus.dmem_hready = 1'b0; bus.dmem_hresp = 1'b0; s_waits--;
      end else if (s_active && s_err && !s_errph) begin
        bus.dmem_hready = 1'b0; bus.dmem_hresp = 1'b1; s_errph = 1;
      end else if (s_active && s_err) begin
        bus.dmem_hready = 1'b1; bus.dmem_hresp = 1'b1;
      end else if (s_active) begin
        bus.dmem_hready = 1'b1; bus.dmem_hresp = 1'b0; bus.dmem_hrdata = s_rdata;
      end else begin
        bus.dmem_hready = 1'b1; bus.dmem_hresp = 1'b0;
      end
    end
  end

  // Model: at most one outstanding transaction; it retires when the bus
  // finishes it (or at once if it was never put on the bus).
  bit          m_valid, m_illegal, m_write;
  logic [31:0] m_hwdata;
  int          m_cnt;
  logic [31:0] rv_log[$];
  bit          e_legal, e_done, e_stall_err, e_gnt, e_err;
  logic [2:0]  e_size;
  logic [1:0]  e_off;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt",    32'(bus.data_gnt),    32'h0);
      chk("rst_rvalid", 32'(bus.data_rvalid), 32'h0);
      chk("rst_htrans", 32'(bus.dmem_htrans), 32'h0);
      chk("rst_hwdata", bus.dmem_hwdata,      32'h0);
      chk("rst_errcnt", 32'(err_count),       32'h0);
      m_valid = 0; m_illegal = 0; m_write = 0; m_hwdata = 32'h0; m_cnt = 0;
    end else begin
      bedec(bus.data_be, e_legal, e_size, e_off);
      e_done      = m_valid && (m_illegal || bus.dmem_hready);
      e_stall_err = m_valid && !m_illegal && bus.dmem_hresp && !bus.dmem_hready;
      e_gnt       = bus.data_req && bus.dmem_hready && !e_stall_err && (!m_valid || e_done);
      e_err       = e_done && (m_illegal || bus.dmem_hresp);
      chk("gnt",    32'(bus.data_gnt),    32'(e_gnt));
      chk("rvalid", 32'(bus.data_rvalid), 32'(e_done));
      chk("err",    32'(bus.data_err),    32'(e_err));
      chk("htrans", 32'(bus.dmem_htrans), (e_gnt && e_legal) ? 32'h2 : 32'h0);
      if (e_gnt && e_legal) begin
        chk("haddr",  bus.dmem_haddr, {bus.data_addr[31:2], e_off});
        chk("hsize",  32'(bus.dmem_hsize),  32'(e_size));
        chk("hwrite", 32'(bus.dmem_hwrite), 32'(bus.data_we));
      end
      chk("hwdata", bus.dmem_hwdata, m_hwdata);
      if (e_done && !m_write && !e_err) begin
        chk("rdata", bus.data_rdata, bus.dmem_hrdata);
        rv_log.push_back(bus.data_rdata);
      end
      chk("err_count", 32'(err_count), 32'(m_cnt));
      chk("ties", {17'h0, bus.dmem_hburst, bus.dmem_hprot, bus.dmem_hmastlock, bus.data_rdata_intg},
          {17'h0, 3'b000, 4'b0011, 1'b0, 7'h00});
      if (e_err && m_cnt < 255) m_cnt++;
      if (e_gnt) begin
        m_valid = 1; m_illegal = !e_legal; m_write = bus.data_we;
        if (e_legal && bus.data_we) m_hwdata = bus.data_wdata;
      end else if (e_done) begin
        m_valid = 0;
      end
    end
  end

  // Present one request and hold it until granted; returns in the next cycle.
  task automatic issue(input bit we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, output int waited, output logic [1:0] ht,
                       output logic [31:0] ha, output logic [2:0] hs);
    bit got;
    waited = 0; got = 0;
    bus.data_req = 1'b1; bus.data_we = we; bus.data_be = be;
    bus.data_addr = addr; bus.data_wdata = wd;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.data_gnt) got = 1;
      else waited++;
    end
    if (!got) begin
      n_chk++;
      $display("FAIL issue_timeout: got no grant, expected grant within 40 cycles");
    end
    ht = bus.dmem_htrans; ha = bus.dmem_haddr; hs = bus.dmem_hsize;
    @(posedge clk); #1;
    bus.data_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int          w, w0, w1, w2;
  logic [1:0]  ht;
  logic [31:0] ha;
  logic [2:0]  hs;
  logic [3:0]  sw_be[7]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  logic [31:0] sw_addr[7] = '{32'h2000, 32'h2001, 32'h2002, 32'h2003, 32'h2000, 32'h2002, 32'h2000};
  logic [2:0]  sw_size[7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2};

  initial begin
    bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_be = 4'h0;
    bus.data_addr = 32'h0; bus.data_wdata = 32'h0; bus.data_wdata_intg = 7'h0;
    #1 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Zero-wait word read
    plan_q.push_back('{0, 1'b0, 32'hDEADBEEF});
    issue(1'b0, 4'b1111, 32'h1000, 32'h0, w, ht, ha, hs);
    chk("rd_wait", 32'(w), 32'h0);
    chk("rd_htrans", 32'(ht), 32'h2);
    chk("rd_haddr", ha, 32'h1000);
    chk("rd_hsize", 32'(hs), 32'h2);
    @(negedge clk);
    chk("rd_rvalid", 32'(bus.data_rvalid), 32'h1);
    chk("rd_rdata", bus.data_rdata, 32'hDEADBEEF);
    chk("rd_err", 32'(bus.data_err), 32'h0);
    idle(1);

    // Byte-enable sweep with writes at 0x2000
    for (int i = 0; i < 7; i++) begin
      issue(1'b1, sw_be[i], 32'h2000, 32'hAABBCCDD, w, ht, ha, hs);
      chk("be_haddr", ha, sw_addr[i]);
      chk("be_hsize", 32'(hs), 32'(sw_size[i]));
      @(negedge clk);
      chk("be_hwdata", bus.dmem_hwdata, 32'hAABBCCDD);
      idle(1);
    end

    // Three back-to-back reads, two wait states on the second
    rv_log.delete();
    plan_q.push_back('{0, 1'b0, 32'h11111111});
    plan_q.push_back('{2, 1'b0, 32'h22222222});
    plan_q.push_back('{0, 1'b0, 32'h33333333});
    issue(1'b0, 4'b1111, 32'h4000, 32'h0, w0, ht, ha, hs);
    issue(1'b0, 4'b1111, 32'h4004, 32'h0, w1, ht, ha, hs);
    issue(1'b0, 4'b1111, 32'h4008, 32'h0, w2, ht, ha, hs);
    chk("pipe_wait0", 32'(w0), 32'h0);
    chk("pipe_wait1", 32'(w1), 32'h0);
    chk("pipe_wait2", 32'(w2), 32'h2);
    idle(2);
    chk("pipe_nrv", 32'(rv_log.size()), 32'h3);
    if (rv_log.size() == 3) begin
      chk("pipe_rv0", rv_log[0], 32'h11111111);
      chk("pipe_rv1", rv_log[1], 32'h22222222);
      chk("pipe_rv2", rv_log[2], 32'h33333333);
    end

    // Illegal byte enables answered locally
    issue(1'b0, 4'b0101, 32'h3000, 32'h0, w, ht, ha, hs);
    chk("ill_wait", 32'(w), 32'h0);
    chk("ill_htrans", 32'(ht), 32'h0);
    @(negedge clk);
    chk("ill_rvalid", 32'(bus.data_rvalid), 32'h1);
    chk("ill_err", 32'(bus.data_err), 32'h1);
    idle(1);
    @(negedge clk);
    chk("ill_errcnt", 32'(err_count), 32'h1);
    idle(1);

    // Two-cycle AHB ERROR on a write with a read pending behind it
    plan_q.push_back('{0, 1'b1, 32'h0});
    issue(1'b1, 4'b1111, 32'h5000, 32'h12345678, w, ht, ha, hs);
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_be = 4'b1111; bus.data_addr = 32'h5004;
    @(negedge clk);
    chk("e1_gnt", 32'(bus.data_gnt), 32'h0);
    chk("e1_htrans", 32'(bus.dmem_htrans), 32'h0);
    chk("e1_rvalid", 32'(bus.data_rvalid), 32'h0);
    idle(1);
    @(negedge clk);
    chk("e2_gnt", 32'(bus.data_gnt), 32'h1);
    chk("e2_rvalid", 32'(bus.data_rvalid), 32'h1);
    chk("e2_err", 32'(bus.data_err), 32'h1);
    chk("e2_htrans", 32'(bus.dmem_htrans), 32'h2);
    idle(1);
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("e3_rdata", bus.data_rdata, 32'hC0DE5004);
    chk("e3_errcnt", 32'(err_count), 32'h2);
    idle(1);

    // Drive the counter to saturation, then past it
    for (int i = 0; i < 256; i++) issue(1'b0, 4'b0101, 32'h3000, 32'h0, w, ht, ha, hs);
    idle(2);
    chk("sat_errcnt", 32'(err_count), 32'hFF);
    plan_q.push_back('{0, 1'b1, 32'h0});
    issue(1'b1, 4'b0011, 32'h5000, 32'h0000BEEF, w, ht, ha, hs);
    idle(3);
    chk("sat_bus_errcnt", 32'(err_count), 32'hFF);

    // Asynchronous reset in the middle of a stalled write
    plan_q.push_back('{5, 1'b0, 32'h0});
    issue(1'b1, 4'b1111, 32'h6000, 32'hCAFEF00D, w, ht, ha, hs);
    @(negedge clk);
    chk("pre_rst_hready", 32'(bus.dmem_hready), 32'h0);
    #2 rst_n = 1'b0;
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_be = 4'b1111; bus.data_addr = 32'h7000;
    #1;
    chk("arst_gnt", 32'(bus.data_gnt), 32'h0);
    chk("arst_rvalid", 32'(bus.data_rvalid), 32'h0);
    chk("arst_htrans", 32'(bus.dmem_htrans), 32'h0);
    chk("arst_hwdata", bus.dmem_hwdata, 32'h0);
    chk("arst_errcnt", 32'(err_count), 32'h0);
    idle(2);
    rst_n = 1'b1;
    bus.data_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'(bus.data_rvalid), 32'h0);
    end
    chk("post_rst_errcnt", 32'(err_count), 32'h0);
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ibex2ahbl_dbus_bridge.md
Name: ibex2ahbl_dbus_bridge

Overview:
Pipelined bridge from the Ibex data-memory interface (req/gnt/rvalid) to a single AHB-Lite master port. Address phase of transfer N overlaps the data phase of transfer N-1. Full byte-enable decoding to HSIZE/HADDR[1:0]; illegal byte-enable patterns are answered locally with an error response and never reach the bus. AHB two-cycle ERROR responses are handled, and bus errors are counted. Sits between the core's LSU port and the AHB-Lite data interconnect.

Parameters:
ADDR_W, 32, address width of data_addr/dmem_haddr (>=3)
HPROT_DATA, 4'b0011, constant driven on dmem_hprot
CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
data_req  in  1  Ibex request, held until data_gnt
data_gnt  out  1  request accepted this cycle
data_rvalid  out  1  response valid (one cycle per granted request)
data_we  in  1  1=write
data_be  in  4  byte enables
data_addr  in  ADDR_W  byte address
data_wdata  in  32  write data, byte lanes already placed by core
data_wdata_intg  in  7  ignored
data_rdata  out  32  read data
data_rdata_intg  out  7  tied 0
data_err  out  1  error qualifier for data_rvalid
dmem_haddr  out  ADDR_W  AHB address
dmem_htrans  out  2  IDLE=2'b00 / NONSEQ=2'b10 only
dmem_hwrite  out  1  AHB write
dmem_hsize  out  3  AHB size
dmem_hburst  out  3  tied 3'b000
dmem_hprot  out  4  HPROT_DATA
dmem_hmastlock  out  1  tied 0
dmem_hwdata  out  32  registered write data
dmem_hready  in  1  AHB HREADY
dmem_hrdata  in  32  AHB read data
dmem_hresp  in  1  AHB HRESP
err_count  out  CNT_W  saturating count of error responses (bus + illegal BE)

Behaviour:
- Reset (rst_n=0, async): dp_valid=0, dp_illegal=0, dmem_hwdata=0, err_count=0; outputs data_gnt=0, data_rvalid=0, dmem_htrans=IDLE. Any in-flight transfer is dropped, no rvalid issued for it.
- BE decode (combinational): 0001->size0,a=00; 0010->size0,01; 0100->size0,10; 1000->size0,11; 0011->size1,00; 1100->size1,10; 1111->size2,00. All other patterns illegal. dmem_haddr={data_addr[ADDR_W-1:2],a}. hwdata lanes unchanged.
- Data-phase register: dp_valid, dp_write, dp_illegal, filled at a grant.
- dp_done = dp_valid & (dp_illegal | dmem_hready). slot_free = !dp_valid | dp_done.
- err_first = dp_valid & !dp_illegal & dmem_hresp & !dmem_hready.
- data_gnt = data_req & slot_free & dmem_hready & !err_first.
- dmem_htrans=NONSEQ iff data_gnt & legal BE; else IDLE. hwrite/hsize/haddr are don't-care while IDLE but driven from the request path.
- On grant: dp_valid<=1, dp_write<=data_we, dp_illegal<=!legal; if legal & data_we, dmem_hwdata<=data_wdata (valid in the following data phase, held until the next legal write grant). With no grant and dp_done: dp_valid<=0.
- data_rvalid = dp_done. data_err = dp_done & (dp_illegal | dmem_hresp). data_rdata = dmem_hrdata (valid for reads only).
- Latency, zero-wait slave: grant in cycle N, rvalid in N+1. Back-to-back: grant every cycle, one rvalid per cycle. Wait states: rvalid is delayed; no further grant until the cycle where HREADY=1.
- Illegal BE: granted like a legal request but HTRANS=IDLE; error rvalid the next cycle regardless of HREADY. Writes are not performed.
- ERROR response: in cycle 1 (HRESP=1, HREADY=0), HTRANS is forced IDLE and gnt=0. In cycle 2 (HRESP=1, HREADY=1), rvalid=1 and err=1; a new grant is allowed in that cycle.
- err_count increments by 1 on each data_rvalid & data_err and saturates at 2^CNT_W-1.

Test Plan:
- Reset: assert rst_n=0 mid-write with slave stalling HREADY=0 -> all outputs at reset values immediately; after release, no spurious rvalid and err_count=0.
- Word read, zero-wait: req addr=0x1000, be=1111 -> cycle0 gnt=1, htrans=NONSEQ, hsize=2, haddr=0x1000; cycle1 rvalid=1, rdata=hrdata=0xDEADBEEF, err=0.
- BE sweep, writes: be=0100 at addr 0x2000 -> haddr=0x2002, hsize=0; be=1100 -> haddr=0x2002, hsize=1. hwdata=0xAABBCCDD unchanged in the data phase after each grant.
- Pipelined with waits: 3 back-to-back reads; slave inserts 2 wait states on the second -> 3 rvalids in order; gnt low during waits; no overlap violation.
- Illegal BE=0101 -> gnt=1, htrans=IDLE, next cycle rvalid=1 err=1, err_count=1.
- AHB error: write, slave returns HRESP=1/HREADY=0 then HRESP=1/HREADY=1 with a pending req -> htrans IDLE and gnt=0 in the first error cycle; rvalid+err and new gnt in the second; err_count increments; at 255 (CNT_W=8) it stays at 255.
